// File: rtl/pocket.sv
// Shared Pocket video types: pixel format, runtime timing record, controller
// state encoding and the timing sanity check used when a new timing is offered.
package pocket;

   localparam int unsigned VT_H_W = 10;
   localparam int unsigned VT_V_W = 9;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef struct packed {
      logic [VT_H_W-1:0] h_total;
      logic [VT_H_W-1:0] h_sync;
      logic [VT_H_W-1:0] h_act_start;
      logic [VT_H_W-1:0] h_act_end;
      logic [VT_V_W-1:0] v_total;
      logic [VT_V_W-1:0] v_sync;
      logic [VT_V_W-1:0] v_act_start;
      logic [VT_V_W-1:0] v_act_end;
   } video_timing_t;

   localparam video_timing_t VIDEO_TIMING_DEFAULT = '{
      h_total:     VT_H_W'(739),
      h_sync:      VT_H_W'(50),
      h_act_start: VT_H_W'(100),
      h_act_end:   VT_H_W'(500),
      v_total:     VT_V_W'(499),
      v_sync:      VT_V_W'(50),
      v_act_start: VT_V_W'(100),
      v_act_end:   VT_V_W'(460)
   };

   typedef enum logic {StIdle, StRun} vt_state_e;

   localparam logic [VT_H_W:0]   H_ONE       = (VT_H_W + 1)'(1);
   localparam logic [VT_V_W:0]   V_ONE       = (VT_V_W + 1)'(1);
   localparam logic [VT_H_W-1:0] H_TOTAL_MIN = VT_H_W'(4);

   // Active window must be non-empty and fit inside total+1; sync must lie on the raster.
   // The +1 compare is done one bit wider so h_total at full scale cannot overflow.
   function automatic logic timing_ok(input video_timing_t c);
      logic ok;
      ok = 1'b1;
      if (c.h_act_start >= c.h_act_end) ok = 1'b0;
      if ({1'b0, c.h_act_end} > ({1'b0, c.h_total} + H_ONE)) ok = 1'b0;
      if (c.h_sync > c.h_total) ok = 1'b0;
      if (c.v_act_start >= c.v_act_end) ok = 1'b0;
      if ({1'b0, c.v_act_end} > ({1'b0, c.v_total} + V_ONE)) ok = 1'b0;
      if (c.v_sync > c.v_total) ok = 1'b0;
      if (c.h_total < H_TOTAL_MIN) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster position counters. While run is high, h sweeps 0..h_total and v
// sweeps 0..v_total; when run is low both are parked at the origin.
module video_timing_counter
   import pocket::*;
#(
   parameter int unsigned H_W = VT_H_W,
   parameter int unsigned V_W = VT_V_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           run,
   input  logic [H_W-1:0] h_total,
   input  logic [V_W-1:0] v_total,
   output logic [H_W-1:0] hcount,
   output logic [V_W-1:0] vcount,
   output logic           frame_wrap
);

   logic line_wrap;

   // Compare against totals before incrementing so counters never overflow.
   assign line_wrap  = run && (hcount == h_total);
   assign frame_wrap = line_wrap && (vcount == v_total);

   // Raster scan while running, held at (0,0) otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount <= '0;
         vcount <= '0;
      end else if (!run) begin
         hcount <= '0;
         vcount <= '0;
      end else if (line_wrap) begin
         hcount <= '0;
         vcount <= frame_wrap ? '0 : vcount + V_W'(1);
      end else begin
         hcount <= hcount + H_W'(1);
      end
   end

endmodule

// File: rtl/video_timing_ctrl.sv
// Pocket video timing controller: accepts runtime timing through a one-entry
// pending slot, swaps it in only at frame boundaries, generates hs/vs/de and
// pulls pixels from the source one cycle ahead of de.
// Optional: define VIDEO_TIMING_FRAME_CNT_EN to add a 16-bit frame_count output.
module video_timing_ctrl
   import pocket::*;
#(
   parameter int unsigned H_W = VT_H_W,
   parameter int unsigned V_W = VT_V_W
) (
   input  logic           rgb_clk,
   input  logic           reset,
   input  logic           en,
   input  video_timing_t  cfg,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   output logic           cfg_err,
   output logic           pix_req,
   input  rgb_t           pix_rgb,
   output logic [H_W-1:0] hcount,
   output logic [V_W-1:0] vcount,
`ifdef VIDEO_TIMING_FRAME_CNT_EN
   output logic [15:0]    frame_count,
`endif
   output rgb_t           rgb,
   output logic           de,
   output logic           skip,
   output logic           vs,
   output logic           hs
);

   vt_state_e     state;
   video_timing_t active_cfg;
   video_timing_t pending_cfg;
   logic          pending_valid;
   logic          run;
   logic          frame_wrap;
   logic          cfg_fire;
   logic          cfg_good;
   logic          act;

   assign cfg_ready = !pending_valid;
   assign cfg_fire  = cfg_valid && cfg_ready;
   assign cfg_good  = timing_ok(cfg);
   assign run       = (state == StRun);

   video_timing_counter #(
      .H_W (H_W),
      .V_W (V_W)
   ) u_counter (
      .clk        (rgb_clk),
      .rst        (reset),
      .run        (run),
      .h_total    (active_cfg.h_total),
      .v_total    (active_cfg.v_total),
      .hcount     (hcount),
      .vcount     (vcount),
      .frame_wrap (frame_wrap)
   );

   // Config slot and run/idle sequencing; timing swaps only at start or frame wrap.
   // A cfg accepted this cycle is not yet visible in pending_valid, so it waits a frame.
   always_ff @(posedge rgb_clk or posedge reset) begin
      if (reset) begin
         state         <= StIdle;
         active_cfg    <= VIDEO_TIMING_DEFAULT;
         pending_cfg   <= VIDEO_TIMING_DEFAULT;
         pending_valid <= 1'b0;
         cfg_err       <= 1'b0;
      end else begin
         // Rejected cfg still completes the handshake; only the error pulse marks it.
         cfg_err <= cfg_fire && !cfg_good;
         if (cfg_fire && cfg_good) begin
            pending_cfg   <= cfg;
            pending_valid <= 1'b1;
         end
         case (state)
            StIdle: begin
               if (en && pending_valid) begin
                  state         <= StRun;
                  active_cfg    <= pending_cfg;
                  pending_valid <= 1'b0;
               end
            end
            StRun: begin
               if (frame_wrap) begin
                  if (pending_valid) begin
                     active_cfg    <= pending_cfg;
                     pending_valid <= 1'b0;
                  end
                  if (!en) state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign act = run
             && (hcount >= active_cfg.h_act_start) && (hcount < active_cfg.h_act_end)
             && (vcount >= active_cfg.v_act_start) && (vcount < active_cfg.v_act_end);
   assign pix_req = act;

   // Video outputs trail the counters by one cycle, aligned with the pixel return.
   always_ff @(posedge rgb_clk or posedge reset) begin
      if (reset) begin
         de <= 1'b0;
         hs <= 1'b0;
         vs <= 1'b0;
      end else begin
         de <= act;
         hs <= run && (hcount == active_cfg.h_sync);
         vs <= run && (vcount == active_cfg.v_sync);
      end
   end

   // The source answers pix_req on the following cycle, exactly when de is high.
   assign rgb  = de ? pix_rgb : '0;
   assign skip = 1'b0;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
   // Frames completed while running; frame_wrap is only ever high in RUN.
   always_ff @(posedge rgb_clk or posedge reset) begin
      if (reset) frame_count <= '0;
      else if (frame_wrap) frame_count <= frame_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl: default timing line check, small-frame
// counts of de/hs/vs, pixel return alignment, mid-frame cfg, bad cfg, stop/resume, reset.
module tb_video_timing_ctrl;
   import pocket::*;

   logic          rgb_clk = 1'b0;
   logic          reset;
   logic          en;
   video_timing_t cfg;
   logic          cfg_valid;
   logic          cfg_ready;
   logic          cfg_err;
   logic          pix_req;
   rgb_t          pix_rgb;
   logic [9:0]    hcount;
   logic [8:0]    vcount;
   rgb_t          rgb;
   logic          de;
   logic          skip;
   logic          vs;
   logic          hs;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
   logic [15:0]   frame_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   // 10x6 raster, active h 2..5, v 1..3, hsync at h=8, vsync on line 5: 60 cycles/frame.
   localparam video_timing_t CFG_A = '{h_total: 10'd9, h_sync: 10'd8, h_act_start: 10'd2,
      h_act_end: 10'd6, v_total: 9'd5, v_sync: 9'd5, v_act_start: 9'd1, v_act_end: 9'd4};
   localparam video_timing_t CFG_B = '{h_total: 10'd9, h_sync: 10'd8, h_act_start: 10'd2,
      h_act_end: 10'd4, v_total: 9'd5, v_sync: 9'd5, v_act_start: 9'd1, v_act_end: 9'd4};
   localparam video_timing_t CFG_BAD = '{h_total: 10'd9, h_sync: 10'd8, h_act_start: 10'd5,
      h_act_end: 10'd2, v_total: 9'd5, v_sync: 9'd5, v_act_start: 9'd1, v_act_end: 9'd4};

   video_timing_ctrl dut (
      .rgb_clk     (rgb_clk),
      .reset       (reset),
      .en          (en),
      .cfg         (cfg),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_err     (cfg_err),
      .pix_req     (pix_req),
      .pix_rgb     (pix_rgb),
      .hcount      (hcount),
      .vcount      (vcount),
`ifdef VIDEO_TIMING_FRAME_CNT_EN
      .frame_count (frame_count),
`endif
      .rgb         (rgb),
      .de          (de),
      .skip        (skip),
      .vs          (vs),
      .hs          (hs)
   );

   always #5 rgb_clk = ~rgb_clk;

   function automatic rgb_t pat(input logic [9:0] h, input logic [8:0] v);
      return '{r: h[7:0], g: v[7:0], b: 8'h3C};
   endfunction

   // Pixel source: answers a request one cycle later, otherwise drives junk.
   always @(posedge rgb_clk) pix_rgb <= pix_req ? pat(hcount, vcount) : rgb_t'(24'h5A5A5A);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic wait_pos(input string tag, input int h, input int v);
      int k;
      k = 0;
      @(negedge rgb_clk);
      while (!(int'(hcount) == h && int'(vcount) == v) && k < 2000) begin
         @(negedge rgb_clk);
         k++;
      end
      check(tag, hcount * 1024 + vcount, h * 1024 + v);
   endtask

   task automatic send_cfg(input video_timing_t c);
      int k;
      k = 0;
      @(negedge rgb_clk);
      cfg = c;
      cfg_valid = 1'b1;
      while (!cfg_ready && k < 2000) begin
         @(negedge rgb_clk);
         k++;
      end
      check("cfg_ready_wait", cfg_ready, 1);
      @(negedge rgb_clk);
      cfg_valid = 1'b0;
   endtask

   // Sample one 60-cycle frame starting at a negedge with counters at (0,0).
   task automatic run_frame(input string tag, input int load_at, input video_timing_t lc,
                            input int off_at, input int on_at,
                            input int x_de, input int x_nrdy, input int x_err);
      int de_n, hs_n, vs_n, err_n, nrdy_n, rgb_bad, first_de;
      logic [9:0] ph;
      logic [8:0] pv;
      rgb_t want;
      de_n = 0; hs_n = 0; vs_n = 0; err_n = 0; nrdy_n = 0; rgb_bad = 0; first_de = -1;
      ph = '0; pv = '0;
      for (int i = 0; i < 60; i++) begin
         if (de) begin
            de_n++;
            if (first_de < 0) first_de = hcount * 256 + vcount;
         end
         want = de ? pat(ph, pv) : '0;
         if (rgb !== want) rgb_bad++;
         if (hs) hs_n++;
         if (vs) vs_n++;
         if (cfg_err) err_n++;
         if (!cfg_ready) nrdy_n++;
         ph = hcount;
         pv = vcount;
         if (i == load_at) begin
            cfg = lc;
            cfg_valid = 1'b1;
         end
         if (i == load_at + 1) cfg_valid = 1'b0;
         if (i == off_at) en = 1'b0;
         if (i == on_at) en = 1'b1;
         @(negedge rgb_clk);
      end
      check({tag, ".de"}, de_n, x_de);
      check({tag, ".hs"}, hs_n, 6);
      check({tag, ".vs"}, vs_n, 10);
      check({tag, ".nrdy"}, nrdy_n, x_nrdy);
      check({tag, ".err"}, err_n, x_err);
      check({tag, ".rgb_bad"}, rgb_bad, 0);
      check({tag, ".first_de"}, first_de, 3 * 256 + 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int de_n, req_n, hs_n, hs_at, busy;
      reset = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg = CFG_A;
      #2 reset = 1'b1;
      repeat (2) @(negedge rgb_clk);
      reset = 1'b0;
      @(negedge rgb_clk);
      check("rst.hcount", hcount, 0);
      check("rst.vcount", vcount, 0);
      check("rst.cfg_ready", cfg_ready, 1);
      check("rst.outs", {de, hs, vs, skip, pix_req, cfg_err}, 0);
      check("rst.rgb", rgb, 0);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
      check("rst.frame_count", frame_count, 0);
`endif

      // Default timing: first line lies above the active area, hsync one cycle after h=50.
      en = 1'b1;
      send_cfg(VIDEO_TIMING_DEFAULT);
      wait_pos("dflt.start", 1, 0);
      de_n = 0; req_n = 0; hs_n = 0; hs_at = -1;
      for (int i = 0; i < 739; i++) begin
         if (de) de_n++;
         if (pix_req) req_n++;
         if (hs) begin
            hs_n++;
            hs_at = hcount;
         end
         @(negedge rgb_clk);
      end
      check("dflt.de", de_n, 0);
      check("dflt.req", req_n, 0);
      check("dflt.hs_n", hs_n, 1);
      check("dflt.hs_at", hs_at, 51);
      check("dflt.wrap", hcount * 1024 + vcount, 1);
      check("dflt.cfg_ready", cfg_ready, 1);

      @(negedge rgb_clk); reset = 1'b1;
      @(negedge rgb_clk); reset = 1'b0;

      // Small raster: counts, pixel alignment, mid-frame reload, bad cfg.
      send_cfg(CFG_A);
      wait_pos("a.sync1", 1, 0);
      wait_pos("a.sync0", 0, 0);
      run_frame("fA", -1, CFG_A, -1, -1, 12, 0, 0);
      run_frame("ld", 20, CFG_B, -1, -1, 12, 39, 0);
      run_frame("fB", -1, CFG_A, -1, -1, 6, 0, 0);
      run_frame("bad", 10, CFG_BAD, -1, -1, 6, 0, 1);
      run_frame("fB2", -1, CFG_A, -1, -1, 6, 0, 0);

      // Stop request mid-frame: frame completes, then IDLE.
      run_frame("stop", -1, CFG_A, 25, -1, 6, 0, 0);
      @(negedge rgb_clk);
      busy = 0;
      for (int i = 0; i < 10; i++) begin
         if (hcount != 0 || vcount != 0 || de || hs || vs || pix_req || rgb != 0) busy++;
         @(negedge rgb_clk);
      end
      check("idle_quiet", busy, 0);

      // Stop then re-enable before the wrap: no pause.
      en = 1'b1;
      send_cfg(CFG_A);
      wait_pos("r.sync1", 1, 0);
      wait_pos("r.sync0", 0, 0);
      run_frame("keep", -1, CFG_A, 15, 45, 12, 0, 0);
      run_frame("nostop", -1, CFG_A, -1, -1, 12, 0, 0);

      // Asynchronous reset mid-frame inside the active window.
      wait_pos("pre_rst", 4, 2);
      check("pre_rst.de", de, 1);
      reset = 1'b1;
      #1;
      check("arst.pos", hcount * 1024 + vcount, 0);
      check("arst.outs", {de, hs, vs, pix_req, cfg_err}, 0);
      check("arst.rgb", rgb, 0);
      check("arst.cfg_ready", cfg_ready, 1);
      @(negedge rgb_clk);
      reset = 1'b0;
      busy = 0;
      for (int i = 0; i < 20; i++) begin
         if (hcount != 0 || vcount != 0 || de || !cfg_ready) busy++;
         @(negedge rgb_clk);
      end
      check("post_rst_idle", busy, 0);

`ifdef VIDEO_TIMING_FRAME_CNT_EN
      send_cfg(CFG_A);
      wait_pos("fc.start", 1, 0);
      check("fc.zero", frame_count, 0);
      for (int i = 0; i < 3; i++) begin
         wait_pos("fc.wrap", 0, 0);
         wait_pos("fc.step", 1, 0);
      end
      check("fc.three", frame_count, 3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
